// File: rtl/b_io_l3_in_serialize_b_m_axi_wburst.sv
// b_io_l3_in_serialize_b_m_axi_wburst
// Serialises a burst-length request plus a first-word-fall-through FIFO into
// an AXI write-data burst. A single output register carries the current beat.
// The register accepts a new word when it is empty or is being drained.
// Optional feature: define WBURST_STATS_EN to add the 16-bit stat_bursts
// output, which counts completed bursts.
module b_io_l3_in_serialize_b_m_axi_wburst #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clk_en,
   input  logic                    len_valid,
   output logic                    len_ready,
   input  logic [LEN_WIDTH-1:0]    len_data,
   input  logic                    data_empty_n,
   output logic                    data_read,
   input  logic [DATA_WIDTH-1:0]   data_dout,
   output logic                    m_axi_WVALID,
   input  logic                    m_axi_WREADY,
   output logic [DATA_WIDTH-1:0]   m_axi_WDATA,
   output logic [DATA_WIDTH/8-1:0] m_axi_WSTRB,
   output logic                    m_axi_WLAST,
   output logic                    burst_done
`ifdef WBURST_STATS_EN
   ,
   output logic [15:0]             stat_bursts
`endif
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t                state_r;
   logic [LEN_WIDTH-1:0]  beats_r;       // beats still to read, minus one
   logic                  remaining_r;   // at least one FIFO word still owed
   logic                  len_ready_r;
   logic                  burst_done_r;
   logic                  wvalid_r;
   logic                  wlast_r;
   logic [DATA_WIDTH-1:0] wdata_r;

   logic                  reg_free_s;
   logic                  read_s;
   logic                  accept_s;
   logic                  beat_hs_s;
   logic                  last_hs_s;
   logic                  load_last_s;

   // Decode handshakes and the FIFO pop condition for the current cycle.
   always_comb begin
      reg_free_s  = ~wvalid_r | m_axi_WREADY;
      beat_hs_s   = clk_en & wvalid_r & m_axi_WREADY;
      last_hs_s   = beat_hs_s & wlast_r;
      load_last_s = (beats_r == {LEN_WIDTH{1'b0}});
      if (state_r == ST_IDLE) begin
         accept_s = clk_en & len_valid & len_ready_r;
         read_s   = 1'b0;
      end else begin
         accept_s = 1'b0;
         read_s   = clk_en & remaining_r & data_empty_n & reg_free_s;
      end
   end

   // Burst sequencing: request acceptance, beat counting, completion pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         len_ready_r  <= 1'b0;
         burst_done_r <= 1'b0;
         beats_r      <= {LEN_WIDTH{1'b0}};
         remaining_r  <= 1'b0;
      end else if (clk_en) begin
         burst_done_r <= last_hs_s;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  state_r     <= ST_BURST;
                  len_ready_r <= 1'b0;
                  beats_r     <= len_data;
                  remaining_r <= 1'b1;
               end else begin
                  len_ready_r <= 1'b1;
               end
            end
            ST_BURST: begin
               // The counter stops at zero; the flag records the final read.
               if (read_s) begin
                  if (load_last_s) begin
                     remaining_r <= 1'b0;
                  end else begin
                     beats_r <= beats_r - LEN_WIDTH'(1);
                  end
               end else begin
                  remaining_r <= remaining_r;
               end
               if (last_hs_s) begin
                  state_r     <= ST_IDLE;
                  len_ready_r <= 1'b1;
               end else begin
                  state_r     <= ST_BURST;
                  len_ready_r <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               len_ready_r <= 1'b0;
               remaining_r <= 1'b0;
               beats_r     <= {LEN_WIDTH{1'b0}};
            end
         endcase
      end else begin
         state_r <= state_r;
      end
   end

   // W-channel output register: load on FIFO pop, empty on accepted beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wvalid_r <= 1'b0;
         wlast_r  <= 1'b0;
         wdata_r  <= {DATA_WIDTH{1'b0}};
      end else if (clk_en) begin
         if (read_s) begin
            wvalid_r <= 1'b1;
            wdata_r  <= data_dout;
            wlast_r  <= load_last_s;
         end else if (beat_hs_s) begin
            wvalid_r <= 1'b0;
            wlast_r  <= 1'b0;
         end else begin
            wvalid_r <= wvalid_r;
         end
      end else begin
         wvalid_r <= wvalid_r;
      end
   end

`ifdef WBURST_STATS_EN
   logic [15:0] stat_bursts_r;

   // Completed-burst counter; wraps from 0xFFFF to 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_bursts_r <= 16'h0000;
      end else if (last_hs_s) begin
         stat_bursts_r <= stat_bursts_r + 16'h0001;
      end else begin
         stat_bursts_r <= stat_bursts_r;
      end
   end

   assign stat_bursts = stat_bursts_r;
`endif

   assign len_ready    = len_ready_r;
   assign burst_done   = burst_done_r;
   assign data_read    = read_s;
   assign m_axi_WVALID = wvalid_r;
   assign m_axi_WDATA  = wdata_r;
   assign m_axi_WLAST  = wlast_r;
   assign m_axi_WSTRB  = {STRB_WIDTH{wvalid_r}};

endmodule

// File: tb/tb_b_io_l3_in_serialize_b_m_axi_wburst.sv
// Self-checking bench for b_io_l3_in_serialize_b_m_axi_wburst.
// The reference model is held as a FIFO queue, a queue of beats that have
// been read but not yet accepted, and burst bookkeeping.
module tb_b_io_l3_in_serialize_b_m_axi_wburst;

   localparam int DW = 32;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          clk_en;
   logic          len_valid;
   logic          len_ready;
   logic [LW-1:0] len_data;
   logic          data_empty_n;
   logic          data_read;
   logic [DW-1:0] data_dout;
   logic          m_axi_WVALID;
   logic          m_axi_WREADY;
   logic [DW-1:0] m_axi_WDATA;
   logic [DW/8-1:0] m_axi_WSTRB;
   logic          m_axi_WLAST;
   logic          burst_done;
`ifdef WBURST_STATS_EN
   logic [15:0]   stat_bursts;
`endif

   b_io_l3_in_serialize_b_m_axi_wburst #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk          (clk),
      .reset        (reset),
      .clk_en       (clk_en),
      .len_valid    (len_valid),
      .len_ready    (len_ready),
      .len_data     (len_data),
      .data_empty_n (data_empty_n),
      .data_read    (data_read),
      .data_dout    (data_dout),
      .m_axi_WVALID (m_axi_WVALID),
      .m_axi_WREADY (m_axi_WREADY),
      .m_axi_WDATA  (m_axi_WDATA),
      .m_axi_WSTRB  (m_axi_WSTRB),
      .m_axi_WLAST  (m_axi_WLAST),
      .burst_done   (burst_done)
`ifdef WBURST_STATS_EN
      ,
      .stat_bursts  (stat_bursts)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] out_d[$];
   bit            out_l[$];
   bit            avail;
   bit            in_burst;
   int            reads_left;
   bit            exp_lr;
   bit            exp_bd;
   int            bursts_model;
   int            beats;
   int            reads;
   int            cyc;
   int            first_cyc;
   int            last_cyc;
   bit            accepted;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic drive_fifo();
      data_empty_n = avail && (fifo_q.size() > 0);
      data_dout    = (fifo_q.size() > 0) ? fifo_q[0] : DW'($urandom);
   endtask

   // One clock: check outputs at negedge, advance the model at posedge.
   task automatic tick();
      bit er, hs, lhs, acc;
      @(negedge clk);
      cyc++;
      er = !reset && clk_en && in_burst && (reads_left > 0) && data_empty_n &&
           ((out_d.size() == 0) || m_axi_WREADY);
      chk("data_read", data_read, er);
      chk("wvalid", m_axi_WVALID, out_d.size() > 0);
      chk("wstrb", m_axi_WSTRB, (out_d.size() > 0) ? 4'hF : 4'h0);
      if (out_d.size() > 0) begin
         chk("wdata", m_axi_WDATA, out_d[0]);
         chk("wlast", m_axi_WLAST, out_l[0]);
      end
      chk("burst_done", burst_done, exp_bd);
      chk("len_ready", len_ready, exp_lr);
`ifdef WBURST_STATS_EN
      chk("stat_bursts", stat_bursts, 16'(bursts_model));
`endif
      hs  = !reset && clk_en && (out_d.size() > 0) && m_axi_WREADY;
      lhs = hs && out_l[0];
      acc = !reset && clk_en && len_valid && exp_lr;
      @(posedge clk);
      if (!reset && clk_en) begin
         if (hs) begin
            beats++;
            if (beats == 1) first_cyc = cyc;
            last_cyc = cyc;
            void'(out_d.pop_front());
            void'(out_l.pop_front());
         end
         if (er) begin
            out_d.push_back(fifo_q[0]);
            out_l.push_back(reads_left == 1);
            void'(fifo_q.pop_front());
            reads_left--;
            reads++;
         end
         if (acc) begin
            in_burst   = 1'b1;
            reads_left = int'(len_data) + 1;
            accepted   = 1'b1;
         end
         if (lhs) begin
            in_burst = 1'b0;
            bursts_model++;
         end
         exp_bd = lhs;
         exp_lr = !in_burst;
      end
      #1;
   endtask

   task automatic run_burst(input int len, input int nwords, input int starve,
                            input int stall_at, input int stall_len, input bit rnd,
                            input bit check_b2b);
      int start_bursts, budget, stalled;
      fifo_q.delete();
      for (int i = 0; i < nwords; i++) fifo_q.push_back(DW'($urandom));
      beats = 0; reads = 0; accepted = 1'b0; stalled = 0; budget = 0;
      start_bursts = bursts_model;
      len_valid = 1'b1;
      len_data  = LW'(len);
      while (bursts_model == start_bursts && budget < 2000) begin
         avail = (budget >= starve) && (!rnd || $urandom_range(0, 3) != 0);
         if (stall_at >= 0 && beats >= stall_at && stalled < stall_len) begin
            m_axi_WREADY = 1'b0;
            stalled++;
         end else begin
            m_axi_WREADY = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
         clk_en = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
         if (accepted) begin
            len_valid = 1'b0;
            len_data  = LW'($urandom);
         end
         drive_fifo();
         tick();
         budget++;
      end
      chk("burst_timeout", budget < 2000, 1'b1);
      len_valid = 1'b0; clk_en = 1'b1; m_axi_WREADY = 1'b1; avail = 1'b1;
      drive_fifo();
      tick();
      tick();
      chk("beats", beats, len + 1);
      chk("reads", reads, len + 1);
      chk("fifo_left", fifo_q.size(), nwords - len - 1);
      if (check_b2b) chk("back_to_back", last_cyc - first_cyc, len);
   endtask

   initial begin
      reset = 1'b1; clk_en = 1'b1; len_valid = 1'b0; len_data = '0;
      m_axi_WREADY = 1'b1; avail = 1'b0;
      in_burst = 1'b0; reads_left = 0; exp_lr = 1'b0; exp_bd = 1'b0;
      bursts_model = 0; cyc = 0; beats = 0; reads = 0;
      drive_fifo();
      tick();
      tick();
      chk("rst_wdata", m_axi_WDATA, 0);
      chk("rst_wlast", m_axi_WLAST, 0);
      reset = 1'b0;
      tick();
      tick();

      // Four-beat burst, data ready, no backpressure.
      run_burst(3, 4, 0, -1, 0, 1'b0, 1'b1);
      // Single-beat burst with one extra word left behind.
      run_burst(0, 2, 0, -1, 0, 1'b0, 1'b1);
      // Eight beats with a 3-cycle WREADY stall mid-burst.
      run_burst(7, 8, 0, 3, 3, 1'b0, 1'b0);
      // Starved FIFO for 5 cycles, two beats, third word unread.
      run_burst(1, 3, 5, -1, 0, 1'b0, 1'b0);
      // Randomised bursts with random WREADY, FIFO availability and clk_en.
      for (int k = 0; k < 8; k++) begin
         int l;
         l = $urandom_range(0, 15);
         run_burst(l, l + 1 + $urandom_range(0, 2), 0, -1, 0, 1'b1, 1'b0);
      end

      // Reset in the middle of a four-beat burst after two beats.
      fifo_q.delete();
      for (int i = 0; i < 4; i++) fifo_q.push_back(DW'($urandom));
      beats = 0; accepted = 1'b0;
      len_valid = 1'b1; len_data = LW'(3); clk_en = 1'b1; m_axi_WREADY = 1'b1; avail = 1'b1;
      for (int b = 0; b < 50 && beats < 2; b++) begin
         if (accepted) len_valid = 1'b0;
         drive_fifo();
         tick();
      end
      chk("rst_prep_beats", beats, 2);
      len_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_async_wvalid", m_axi_WVALID, 1'b0);
      chk("rst_async_wlast", m_axi_WLAST, 1'b0);
      chk("rst_async_wdata", m_axi_WDATA, 0);
      chk("rst_async_len_ready", len_ready, 1'b0);
      chk("rst_async_burst_done", burst_done, 1'b0);
      chk("rst_async_data_read", data_read, 1'b0);
      out_d.delete(); out_l.delete();
      in_burst = 1'b0; reads_left = 0; exp_lr = 1'b0; exp_bd = 1'b0; bursts_model = 0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();
      chk("post_rst_len_ready", len_ready, 1'b1);
      // Fresh burst after the abandoned one.
      run_burst(2, 3, 0, -1, 0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/b_io_l3_in_serialize_b_m_axi_wburst.md
B_IO_L3_IN_SERIALIZE_B_M_AXI_WBURST -- requirements
Module: B_IO_L3_in_serialize_B_m_axi_wburst

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of FIFO word and WDATA.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, width of burst length (AXI AWLEN semantics: beats minus 1).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clk_en  input  1  global enable; low freezes all state.
REQ-006 SHALL have ports len_valid input 1, len_ready output 1, len_data input LEN_WIDTH: burst-length request handshake.
REQ-007 SHALL have ports data_empty_n input 1, data_read output 1, data_dout input DATA_WIDTH: first-word-fall-through FIFO read side.
REQ-008 SHALL have ports m_axi_WVALID output 1, m_axi_WREADY input 1, m_axi_WDATA output DATA_WIDTH, m_axi_WSTRB output DATA_WIDTH/8, m_axi_WLAST output 1: AXI write-data channel.
REQ-009 SHALL have port burst_done  output  1  one-cycle pulse after final beat of a burst is accepted.

Function
REQ-010 SHALL implement two states: IDLE and BURST.
REQ-011 SHALL assert len_ready only in IDLE; len_valid & len_ready & clk_en loads beat counter with len_data and enters BURST next cycle.
REQ-012 SHALL hold the W channel in a single output register (WVALID, WDATA, WLAST); register is "free" when WVALID=0 or WVALID & WREADY.
REQ-013 SHALL assert data_read combinationally = BURST & beats_remaining & data_empty_n & register free & clk_en.
REQ-014 SHALL load data_dout into WDATA on data_read, setting WVALID=1 next cycle; first beat appears no earlier than 1 cycle after entering BURST.
REQ-015 SHALL decrement the beat counter on each data_read; WLAST SHALL be 1 on the beat loaded when the counter is 0.
REQ-016 SHALL sustain one beat per cycle when data_empty_n and WREADY stay high (no bubbles).
REQ-017 SHALL hold WVALID, WDATA, WLAST stable while WVALID=1 and WREADY=0.
REQ-018 SHALL drive m_axi_WSTRB all-ones whenever WVALID=1, zero otherwise.
REQ-019 SHALL, on handshake of the WLAST beat, pulse burst_done for one cycle and return to IDLE; len_ready SHALL be 1 the following cycle.
REQ-020 SHALL never read the FIFO beyond len_data+1 words per burst; data_empty_n low SHALL insert bubbles (WVALID=0), not errors.
REQ-021 SHALL treat len_data=0 as a single-beat burst with WLAST on that beat.
REQ-022 SHALL freeze state, counter and output register when clk_en=0; data_read SHALL be 0.

Reset
REQ-023 SHALL, on reset assertion, immediately force IDLE, counter 0, WVALID=0, WLAST=0, WDATA=0, burst_done=0, len_ready=0.
REQ-024 SHALL set len_ready=1 on the first clk_en cycle after reset release.
REQ-025 SHALL abandon any in-flight burst on reset with no WLAST issued; the buffered word is discarded.

Configuration
REQ-026 SHALL, with macro WBURST_STATS_EN defined, add output stat_bursts (16 bits) counting burst_done pulses, reset to 0, wrapping 0xFFFF->0.
REQ-027 SHALL, without WBURST_STATS_EN, omit stat_bursts and its counter entirely; all other behaviour identical.

Verification
REQ-028 SHALL cover: len_data=3, FIFO holds 4 words, WREADY=1 -> 4 consecutive beats, WLAST on 4th, burst_done 1 cycle later, len_ready high next cycle.
REQ-029 SHALL cover: len_data=0 -> single beat with WLAST=1, exactly one data_read.
REQ-030 SHALL cover: len_data=7, WREADY low for 3 cycles mid-burst -> WDATA/WLAST stable while stalled, no extra data_read, 8 beats total.
REQ-031 SHALL cover: len_data=1, FIFO empty 5 cycles then 2 words -> WVALID=0 during starvation, then 2 beats, FIFO word 3 left unread.
REQ-032 SHALL cover: reset asserted after 2 of 4 beats -> WVALID drops same cycle, no WLAST, IDLE and len_ready=1 one clk_en cycle after release; with WBURST_STATS_EN, stat_bursts=0.
